// File: rtl/cmd_fifo_arb.sv
// Two-requester round-robin arbiter in front of the cmd_fifo push port.
// A multi-beat write burst keeps its grant until the last beat, so bursts never interleave.
module cmd_fifo_arb #(
    parameter int TYPE_WIDTH = 2,
    parameter int ADDR_WIDTH = 27,
    parameter int BRST_WIDTH = 6,
    parameter int DATA_WIDTH = 128,
    parameter int MASK_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  io_m0_valid,
    output logic                  io_m0_ready,
    input  logic [TYPE_WIDTH-1:0] io_m0_cmd_type,
    input  logic [ADDR_WIDTH-1:0] io_m0_addr,
    input  logic [BRST_WIDTH-1:0] io_m0_burst_cnt,
    input  logic [DATA_WIDTH-1:0] io_m0_wt_data,
    input  logic [MASK_WIDTH-1:0] io_m0_wt_mask,
    input  logic                  io_m1_valid,
    output logic                  io_m1_ready,
    input  logic [TYPE_WIDTH-1:0] io_m1_cmd_type,
    input  logic [ADDR_WIDTH-1:0] io_m1_addr,
    input  logic [BRST_WIDTH-1:0] io_m1_burst_cnt,
    input  logic [DATA_WIDTH-1:0] io_m1_wt_data,
    input  logic [MASK_WIDTH-1:0] io_m1_wt_mask,
    output logic                  io_push_valid,
    input  logic                  io_push_ready,
    output logic [TYPE_WIDTH-1:0] io_push_cmd_type,
    output logic [ADDR_WIDTH-1:0] io_push_addr,
    output logic [BRST_WIDTH-1:0] io_push_burst_cnt,
    output logic [DATA_WIDTH-1:0] io_push_wt_data,
    output logic [MASK_WIDTH-1:0] io_push_wt_mask,
    output logic                  io_push_src,
    output logic                  io_proto_err
);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    localparam logic [TYPE_WIDTH-1:0] TYPE_WT = TYPE_WIDTH'(2);

    state_t                  state_q, state_d;
    logic                    rr_ptr_q, rr_ptr_d;
    logic                    lock_src_q, lock_src_d;
    logic [BRST_WIDTH-1:0]   beat_cnt_q, beat_cnt_d;
    logic [BRST_WIDTH-1:0]   burst_len_q, burst_len_d;
    logic                    proto_err_q, proto_err_d;

    logic                    sel;
    logic                    sel_valid;
    logic                    xfer;

    // Selection uses only pre-update state, so a request racing the last burst beat waits a cycle.
    always_comb begin
        sel = rr_ptr_q;
        if (state_q == BURST) begin
            sel = lock_src_q;
        end else if (io_m0_valid && !io_m1_valid) begin
            sel = 1'b0;
        end else if (io_m1_valid && !io_m0_valid) begin
            sel = 1'b1;
        end
    end

    always_comb begin
        sel_valid         = io_m0_valid;
        io_push_cmd_type  = io_m0_cmd_type;
        io_push_addr      = io_m0_addr;
        io_push_burst_cnt = io_m0_burst_cnt;
        io_push_wt_data   = io_m0_wt_data;
        io_push_wt_mask   = io_m0_wt_mask;
        if (sel) begin
            sel_valid         = io_m1_valid;
            io_push_cmd_type  = io_m1_cmd_type;
            io_push_addr      = io_m1_addr;
            io_push_burst_cnt = io_m1_burst_cnt;
            io_push_wt_data   = io_m1_wt_data;
            io_push_wt_mask   = io_m1_wt_mask;
        end
    end

    assign io_push_src   = sel;
    assign io_push_valid = sel_valid && !rst;
    assign io_m0_ready   = !rst && !sel && io_push_ready;
    assign io_m1_ready   = !rst && sel && io_push_ready;
    assign io_proto_err  = proto_err_q && !rst;
    assign xfer          = io_push_valid && io_push_ready;

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        lock_src_d  = lock_src_q;
        beat_cnt_d  = beat_cnt_q;
        burst_len_d = burst_len_q;
        proto_err_d = 1'b0;
        if (xfer) begin
            if (state_q == IDLE) begin
                if (io_push_cmd_type == TYPE_WT && io_push_burst_cnt != '0) begin
                    state_d     = BURST;
                    lock_src_d  = sel;
                    burst_len_d = io_push_burst_cnt;
                    beat_cnt_d  = BRST_WIDTH'(1);
                end else begin
                    rr_ptr_d = ~sel;
                end
            end else begin
                proto_err_d = (io_push_cmd_type != TYPE_WT) ||
                              (io_push_burst_cnt != burst_len_q);
                // beat_cnt tops out at burst_len, which fits in BRST_WIDTH bits.
                if (beat_cnt_q == burst_len_q) begin
                    state_d    = IDLE;
                    beat_cnt_d = '0;
                    rr_ptr_d   = ~lock_src_q;
                end else begin
                    beat_cnt_d = beat_cnt_q + BRST_WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= 1'b0;
            lock_src_q  <= 1'b0;
            beat_cnt_q  <= '0;
            burst_len_q <= '0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            lock_src_q  <= lock_src_d;
            beat_cnt_q  <= beat_cnt_d;
            burst_len_q <= burst_len_d;
            proto_err_q <= proto_err_d;
        end
    end

endmodule

// File: tb/tb_cmd_fifo_arb.sv
// Directed bench for cmd_fifo_arb: stimulus pushes expected push-port beats into a
// scoreboard queue, and a negedge monitor pops and compares every accepted beat.
module tb_cmd_fifo_arb;

    localparam logic [1:0] T_CMD = 2'd1;
    localparam logic [1:0] T_WT  = 2'd2;
    localparam logic [1:0] T_RD  = 2'd3;

    typedef struct packed {
        logic         src;
        logic [1:0]   t;
        logic [26:0]  a;
        logic [5:0]   b;
        logic [127:0] d;
        logic [15:0]  m;
    } beat_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         m0_valid, m0_ready, m1_valid, m1_ready;
    logic [1:0]   m0_type, m1_type;
    logic [26:0]  m0_addr, m1_addr;
    logic [5:0]   m0_burst, m1_burst;
    logic [127:0] m0_data, m1_data;
    logic [15:0]  m0_mask, m1_mask;
    logic         push_valid, push_ready, push_src, proto_err;
    logic [1:0]   push_type;
    logic [26:0]  push_addr;
    logic [5:0]   push_burst;
    logic [127:0] push_data;
    logic [15:0]  push_mask;

    beat_t        sb[$];
    int           total = 0;
    int           bad = 0;
    logic [127:0] base_a;

    cmd_fifo_arb dut (
        .clk(clk), .rst(rst),
        .io_m0_valid(m0_valid), .io_m0_ready(m0_ready), .io_m0_cmd_type(m0_type),
        .io_m0_addr(m0_addr), .io_m0_burst_cnt(m0_burst), .io_m0_wt_data(m0_data),
        .io_m0_wt_mask(m0_mask),
        .io_m1_valid(m1_valid), .io_m1_ready(m1_ready), .io_m1_cmd_type(m1_type),
        .io_m1_addr(m1_addr), .io_m1_burst_cnt(m1_burst), .io_m1_wt_data(m1_data),
        .io_m1_wt_mask(m1_mask),
        .io_push_valid(push_valid), .io_push_ready(push_ready),
        .io_push_cmd_type(push_type), .io_push_addr(push_addr),
        .io_push_burst_cnt(push_burst), .io_push_wt_data(push_data),
        .io_push_wt_mask(push_mask), .io_push_src(push_src), .io_proto_err(proto_err)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input bit idx, input logic v, input logic [1:0] t,
                                  input logic [26:0] a, input logic [5:0] b,
                                  input logic [127:0] d, input logic [15:0] m);
        if (idx == 1'b0) begin
            m0_valid = v; m0_type = t; m0_addr = a; m0_burst = b; m0_data = d; m0_mask = m;
        end else begin
            m1_valid = v; m1_type = t; m1_addr = a; m1_burst = b; m1_data = d; m1_mask = m;
        end
    endtask

    task automatic expect_beat(input logic s, input logic [1:0] t, input logic [26:0] a,
                               input logic [5:0] b, input logic [127:0] d, input logic [15:0] m);
        beat_t e;
        e.src = s; e.t = t; e.a = a; e.b = b; e.d = d; e.m = m;
        sb.push_back(e);
    endtask

    task automatic cycle_step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        @(negedge clk);
        check_output({tag, "_push_valid"}, 128'(push_valid), 128'(0));
        check_output({tag, "_m0_ready"}, 128'(m0_ready), 128'(0));
        check_output({tag, "_m1_ready"}, 128'(m1_ready), 128'(0));
        check_output({tag, "_proto_err"}, 128'(proto_err), 128'(0));
    endtask

    task automatic check_drained(input string tag);
        check_output({tag, "_queue_left"}, 128'(sb.size()), 128'(0));
        sb.delete();
    endtask

    // Every accepted beat must match the head of the scoreboard.
    always @(negedge clk) begin
        if (push_valid && push_ready) begin
            beat_t act;
            beat_t exp;
            act.src = push_src; act.t = push_type; act.a = push_addr;
            act.b = push_burst; act.d = push_data; act.m = push_mask;
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("[TB] FAIL beat_unexpected: got src=%0d addr=%0h expected no beat", push_src, push_addr);
            end else begin
                exp = sb.pop_front();
                if (act !== exp) begin
                    bad++;
                    $display("[TB] FAIL beat: got src=%0d t=%0d a=%0h b=%0d d=%0h m=%0h expected src=%0d t=%0d a=%0h b=%0d d=%0h m=%0h",
                             act.src, act.t, act.a, act.b, act.d, act.m,
                             exp.src, exp.t, exp.a, exp.b, exp.d, exp.m);
                end
            end
        end
    end

    initial begin
        base_a = 128'h0123456789abcdeffedcba9876543210;
        rst = 1'b1;
        push_ready = 1'b1;
        apply_stimulus(1'b0, 1'b1, T_RD, 27'h100, 6'd7, 128'hA0, 16'h000A);
        apply_stimulus(1'b1, 1'b1, T_RD, 27'h200, 6'd7, 128'hB0, 16'h000B);
        check_reset_outputs("reset");
        cycle_step();
        rst = 1'b0;

        // Both requesters hold RD: strict alternation starting at m0.
        expect_beat(1'b0, T_RD, 27'h100, 6'd7, 128'hA0, 16'h000A);
        expect_beat(1'b1, T_RD, 27'h200, 6'd7, 128'hB0, 16'h000B);
        expect_beat(1'b0, T_RD, 27'h100, 6'd7, 128'hA0, 16'h000A);
        expect_beat(1'b1, T_RD, 27'h200, 6'd7, 128'hB0, 16'h000B);
        @(negedge clk);
        check_output("rr_first_src", 128'(push_src), 128'(0));
        cycle_step();
        repeat (3) cycle_step();
        m0_valid = 1'b0; m1_valid = 1'b0;
        check_drained("rr");

        // m0 write burst of 8 beats; m1 read arrives at beat 2 and must wait.
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(1'b0, 1'b1, T_WT, 27'h400, 6'd7, base_a + 128'(i), 16'hff00 ^ 16'(i));
            expect_beat(1'b0, T_WT, 27'h400, 6'd7, base_a + 128'(i), 16'hff00 ^ 16'(i));
            if (i == 1) apply_stimulus(1'b1, 1'b1, T_RD, 27'h300, 6'd0, 128'hC1, 16'h00C1);
            @(negedge clk);
            check_output("lock_m1_ready", 128'(m1_ready), 128'(0));
            check_output("lock_src", 128'(push_src), 128'(0));
            cycle_step();
        end
        m0_valid = 1'b0;
        expect_beat(1'b1, T_RD, 27'h300, 6'd0, 128'hC1, 16'h00C1);
        @(negedge clk);
        check_output("after_burst_m1_ready", 128'(m1_ready), 128'(1));
        cycle_step();
        m1_valid = 1'b0;
        check_drained("lock");

        // Backpressure: 4-beat write with push_ready toggling, m1 waiting behind it.
        apply_stimulus(1'b1, 1'b1, T_RD, 27'h310, 6'd0, 128'hC2, 16'h00C2);
        begin
            int beat;
            beat = 0;
            for (int k = 0; k < 8; k++) begin
                push_ready = (k % 2 == 0);
                if (beat < 4) begin
                    apply_stimulus(1'b0, 1'b1, T_WT, 27'h420, 6'd3, base_a + 128'(16 + beat), 16'h0f0f + 16'(beat));
                    if (push_ready) expect_beat(1'b0, T_WT, 27'h420, 6'd3, base_a + 128'(16 + beat), 16'h0f0f + 16'(beat));
                end else begin
                    m0_valid = 1'b0;
                end
                @(negedge clk);
                if (beat < 4) begin
                    check_output("bp_data", push_data, base_a + 128'(16 + beat));
                    check_output("bp_mask", 128'(push_mask), 128'(16'h0f0f + 16'(beat)));
                    check_output("bp_m1_ready", 128'(m1_ready), 128'(0));
                end
                cycle_step();
                if (push_ready && beat < 4) beat++;
            end
        end
        m0_valid = 1'b0;
        push_ready = 1'b1;
        expect_beat(1'b1, T_RD, 27'h310, 6'd0, 128'hC2, 16'h00C2);
        cycle_step();
        m1_valid = 1'b0;
        check_drained("bp");

        // 64-beat burst (rr_ptr is 0 here), then a tie must go to m1.
        for (int i = 0; i < 64; i++) begin
            apply_stimulus(1'b0, 1'b1, T_WT, 27'h440, 6'd63, base_a + 128'(100 + i), 16'(i));
            expect_beat(1'b0, T_WT, 27'h440, 6'd63, base_a + 128'(100 + i), 16'(i));
            cycle_step();
        end
        apply_stimulus(1'b0, 1'b1, T_RD, 27'h600, 6'd0, 128'hD0, 16'h00D0);
        apply_stimulus(1'b1, 1'b1, T_RD, 27'h500, 6'd0, 128'hE0, 16'h00E0);
        expect_beat(1'b1, T_RD, 27'h500, 6'd0, 128'hE0, 16'h00E0);
        expect_beat(1'b0, T_RD, 27'h600, 6'd0, 128'hD0, 16'h00D0);
        repeat (2) cycle_step();
        m0_valid = 1'b0; m1_valid = 1'b0;
        check_drained("maxburst");

        // Single-beat WT from m1 flips rr_ptr to 0, so the next tie goes to m0.
        apply_stimulus(1'b1, 1'b1, T_WT, 27'h510, 6'd0, 128'hE1, 16'h00E1);
        expect_beat(1'b1, T_WT, 27'h510, 6'd0, 128'hE1, 16'h00E1);
        cycle_step();
        apply_stimulus(1'b0, 1'b1, T_CMD, 27'h610, 6'd0, 128'hD1, 16'h00D1);
        apply_stimulus(1'b1, 1'b1, T_RD, 27'h520, 6'd0, 128'hE2, 16'h00E2);
        expect_beat(1'b0, T_CMD, 27'h610, 6'd0, 128'hD1, 16'h00D1);
        expect_beat(1'b1, T_RD, 27'h520, 6'd0, 128'hE2, 16'h00E2);
        repeat (2) cycle_step();
        m0_valid = 1'b0; m1_valid = 1'b0;
        check_drained("single_wt");

        // m1 8-beat burst with an RD type on the third beat.
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(1'b1, 1'b1, (i == 2) ? T_RD : T_WT, 27'h700, 6'd7, base_a + 128'(200 + i), 16'h1111);
            expect_beat(1'b1, (i == 2) ? T_RD : T_WT, 27'h700, 6'd7, base_a + 128'(200 + i), 16'h1111);
            @(negedge clk);
            check_output("proto_err", 128'(proto_err), 128'(i == 3));
            cycle_step();
        end
        m1_valid = 1'b0;
        @(negedge clk);
        check_output("proto_err_end", 128'(proto_err), 128'(0));
        apply_stimulus(1'b0, 1'b1, T_RD, 27'h620, 6'd0, 128'hD2, 16'h00D2);
        expect_beat(1'b0, T_RD, 27'h620, 6'd0, 128'hD2, 16'h00D2);
        cycle_step();
        m0_valid = 1'b0;
        check_drained("proto");

        // rr_ptr is now 1; reset in the middle of an m1 burst must clear it.
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1'b1, 1'b1, T_WT, 27'h800, 6'd7, base_a + 128'(300 + i), 16'h2222);
            expect_beat(1'b1, T_WT, 27'h800, 6'd7, base_a + 128'(300 + i), 16'h2222);
            cycle_step();
        end
        apply_stimulus(1'b1, 1'b1, T_WT, 27'h800, 6'd7, base_a + 128'(304), 16'h2222);
        apply_stimulus(1'b0, 1'b1, T_RD, 27'h630, 6'd0, 128'hD3, 16'h00D3);
        rst = 1'b1;
        check_reset_outputs("midrst");
        cycle_step();
        rst = 1'b0;
        apply_stimulus(1'b1, 1'b1, T_RD, 27'h530, 6'd0, 128'hE3, 16'h00E3);
        expect_beat(1'b0, T_RD, 27'h630, 6'd0, 128'hD3, 16'h00D3);
        expect_beat(1'b1, T_RD, 27'h530, 6'd0, 128'hE3, 16'h00E3);
        @(negedge clk);
        check_output("post_rst_src", 128'(push_src), 128'(0));
        cycle_step();
        cycle_step();
        m0_valid = 1'b0; m1_valid = 1'b0;
        repeat (2) cycle_step();
        check_drained("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
